// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: register map, CSR bit positions and the
// byte shifted out when the master clocks a byte the CPU never supplied.
package spi_target_pkg;

  typedef enum logic [1:0] {
    REG_CSR   = 2'd0,
    REG_DATA  = 2'd1,
    REG_LEVEL = 2'd2,
    REG_RSVD  = 2'd3
  } reg_addr_e;

  localparam int CSR_RX_NE   = 0;
  localparam int CSR_TX_FULL = 1;
  localparam int CSR_RX_OVR  = 2;
  localparam int CSR_TX_UNR  = 3;
  localparam int CSR_SEL     = 4;
  localparam int CSR_RX_IE   = 8;
  localparam int CSR_TX_IE   = 9;

  localparam logic [7:0] UNDERRUN_FILL = 8'hFF;

endpackage

// File: rtl/spi_target_if.sv
// Wishbone CSR port of the SPI target; the bus initiator uses the master modport.
interface spi_target_if;

  logic [1:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );

endinterface

// File: rtl/spi_target_fifo.sv
// Synchronous byte FIFO with a level counter; a push to a full FIFO is taken
// when a pop happens in the same cycle, and a pop from an empty FIFO does nothing.
module spi_target_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_data,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_doPush;
  logic                  w_doPop;

  assign o_empty  = (r_level == '0);
  assign o_full   = (r_level == (DEPTH_LOG2+1)'(DEPTH));
  assign o_level  = r_level;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_doPush && !w_doPop)      r_level <= r_level + 1'b1;
      else if (w_doPop && !w_doPush) r_level <= r_level - 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target (MSB first) with Wishbone CSRs, RX/TX FIFOs and an interrupt.
// Define SPI_TARGET_IRQ_EN to build the interrupt enables and irqo_spi.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_pad_clk,
  input  logic        spi_pad_cs_n,
  input  logic        spi_pad_mosi,
  output logic        spi_pad_miso,
  output logic        spi_pad_miso_oe,
  output logic        irqo_spi,
  spi_target_if.slave wb
);

  logic [2:0] r_sclkSync;
  logic [2:0] r_csSync;
  logic [1:0] r_mosiSync;
  logic [2:0] r_bitCnt;
  logic [6:0] r_rxShift;
  logic [7:0] r_txShift;
  logic       r_misoOe;
  logic       r_rxOverrun;
  logic       r_txUnderrun;
  logic       r_ack;
  logic [31:0] r_rdata;

  logic w_sclkRise, w_sclkFall, w_csFall, w_csRise, w_selected;
  logic w_rxPush, w_rxPop, w_rxEmpty, w_rxFull, w_rxOverSet;
  logic w_txLoad, w_txPush, w_txEmpty, w_txFull;
  logic [7:0] w_rxByte, w_rxHead, w_txHead, w_txByte;
  logic [RX_DEPTH_LOG2:0] w_rxLevel;
  logic [TX_DEPTH_LOG2:0] w_txLevel;
  logic w_stb, w_csrWrite, w_rxIrqEn, w_txIrqEn, w_unused;
  reg_addr_e w_addr;
  logic [31:0] w_rdMux;

  // Pad oversampling: two metastability flops plus one history flop per edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclkSync <= 3'b000;
      r_csSync   <= 3'b111;
      r_mosiSync <= 2'b00;
    end else begin
      r_sclkSync <= {r_sclkSync[1:0], spi_pad_clk};
      r_csSync   <= {r_csSync[1:0], spi_pad_cs_n};
      r_mosiSync <= {r_mosiSync[0], spi_pad_mosi};
    end
  end

  assign w_sclkRise = r_sclkSync[1] & ~r_sclkSync[2];
  assign w_sclkFall = ~r_sclkSync[1] & r_sclkSync[2];
  assign w_csFall   = ~r_csSync[1] & r_csSync[2];
  assign w_csRise   = r_csSync[1] & ~r_csSync[2];
  assign w_selected = ~r_csSync[1];

  assign w_txLoad = w_csFall | (w_selected & w_sclkFall & (r_bitCnt == 3'd0));
  assign w_txByte = w_txEmpty ? UNDERRUN_FILL : w_txHead;
  assign w_rxByte = {r_rxShift, r_mosiSync[1]};
  assign w_rxPush = ~w_csFall & w_selected & w_sclkRise & (r_bitCnt == 3'd7);
  assign w_rxOverSet = w_rxPush & w_rxFull & ~w_rxPop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitCnt  <= '0;
      r_rxShift <= '0;
      r_txShift <= '0;
      r_misoOe  <= 1'b0;
    end else begin
      r_misoOe <= w_selected;
      if (w_csFall) begin
        r_bitCnt  <= '0;
        r_txShift <= w_txByte;
      end else if (w_csRise) begin
        r_bitCnt <= '0;
      end else if (w_selected) begin
        if (w_sclkRise) begin
          r_rxShift <= w_rxByte[6:0];
          r_bitCnt  <= r_bitCnt + 3'd1;
        end
        if (w_sclkFall) begin
          if (r_bitCnt == 3'd0) r_txShift <= w_txByte;
          else                  r_txShift <= {r_txShift[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_pad_miso    = r_txShift[7];
  assign spi_pad_miso_oe = r_misoOe;

  assign w_stb      = wb.wb_cyc & ~r_ack;
  assign w_addr     = reg_addr_e'(wb.wb_addr);
  assign w_rxPop    = w_stb & ~wb.wb_we & (w_addr == REG_DATA);
  assign w_txPush   = w_stb &  wb.wb_we & (w_addr == REG_DATA);
  assign w_csrWrite = w_stb &  wb.wb_we & (w_addr == REG_CSR);
  assign w_unused   = ^wb.wb_wdata;

  spi_target_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rxFifo (
    .clk(clk), .rst(rst), .i_push(w_rxPush), .i_pop(w_rxPop), .i_data(w_rxByte),
    .o_data(w_rxHead), .o_empty(w_rxEmpty), .o_full(w_rxFull), .o_level(w_rxLevel)
  );

  spi_target_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_txFifo (
    .clk(clk), .rst(rst), .i_push(w_txPush), .i_pop(w_txLoad), .i_data(wb.wb_wdata[7:0]),
    .o_data(w_txHead), .o_empty(w_txEmpty), .o_full(w_txFull), .o_level(w_txLevel)
  );

  always_comb begin
    w_rdMux = '0;
    case (w_addr)
      REG_CSR: begin
        w_rdMux[CSR_RX_NE]   = ~w_rxEmpty;
        w_rdMux[CSR_TX_FULL] = w_txFull;
        w_rdMux[CSR_RX_OVR]  = r_rxOverrun;
        w_rdMux[CSR_TX_UNR]  = r_txUnderrun;
        w_rdMux[CSR_SEL]     = w_selected;
        w_rdMux[CSR_RX_IE]   = w_rxIrqEn;
        w_rdMux[CSR_TX_IE]   = w_txIrqEn;
      end
      REG_DATA:  w_rdMux = {~w_rxEmpty, 23'd0, w_rxEmpty ? 8'h00 : w_rxHead};
      REG_LEVEL: w_rdMux = {16'd0, 8'(w_txLevel), 8'(w_rxLevel)};
      default:   w_rdMux = '0;
    endcase
  end

  // A flag being set in the same cycle as its write-1-to-clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack        <= 1'b0;
      r_rdata      <= '0;
      r_rxOverrun  <= 1'b0;
      r_txUnderrun <= 1'b0;
    end else begin
      r_ack        <= wb.wb_cyc & ~r_ack;
      r_rdata      <= w_stb ? w_rdMux : 32'd0;
      r_rxOverrun  <= w_rxOverSet | (r_rxOverrun & ~(w_csrWrite & wb.wb_wdata[CSR_RX_OVR]));
      r_txUnderrun <= (w_txLoad & w_txEmpty) |
                      (r_txUnderrun & ~(w_csrWrite & wb.wb_wdata[CSR_TX_UNR]));
    end
  end

  assign wb.wb_ack   = r_ack;
  assign wb.wb_rdata = r_rdata;

`ifdef SPI_TARGET_IRQ_EN
  logic r_rxIrqEn, r_txIrqEn, r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxIrqEn <= 1'b0;
      r_txIrqEn <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_csrWrite) begin
        r_rxIrqEn <= wb.wb_wdata[CSR_RX_IE];
        r_txIrqEn <= wb.wb_wdata[CSR_TX_IE];
      end
      r_irq <= (r_rxIrqEn & ~w_rxEmpty) | (r_txIrqEn & w_txEmpty);
    end
  end

  assign w_rxIrqEn = r_rxIrqEn;
  assign w_txIrqEn = r_txIrqEn;
  assign irqo_spi  = r_irq;
`else
  assign w_rxIrqEn = 1'b0;
  assign w_txIrqEn = 1'b0;
  assign irqo_spi  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Randomised bench for spi_target: an SPI master and Wishbone initiator drive the
// DUT while a queue-based model of FIFOs, flags and the MISO byte stream predicts outputs.
module tb_spi_target;

  localparam int DEPTH = 16;
  localparam int HALF  = 5;

  logic clk = 1'b0;
  logic rst;
  logic spiClk, spiCs, spiMosi;
  logic miso, misoOe, irq;

  spi_target_if wbIf ();

  spi_target #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .spi_pad_clk(spiClk), .spi_pad_cs_n(spiCs), .spi_pad_mosi(spiMosi),
    .spi_pad_miso(miso), .spi_pad_miso_oe(misoOe), .irqo_spi(irq),
    .wb(wbIf)
  );

  always #5 clk = ~clk;

  int errCount = 0;
  int checkCount = 0;

  // Behavioural model state
  logic [7:0]  rxQ[$];
  logic [7:0]  txQ[$];
  logic        mRxOvr = 1'b0, mTxUnr = 1'b0, mRxIe = 1'b0, mTxIe = 1'b0, mSel = 1'b0;
  logic [7:0]  mCurTx = 8'h00;
  logic [7:0]  mRxShift = 8'h00;
  int          mBitCnt = 0;
  logic [31:0] expRdata = '0;
  logic        expValid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] modelTxFetch();
    if (txQ.size() == 0) begin
      mTxUnr = 1'b1;
      return 8'hFF;
    end
    return txQ.pop_front();
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] addr);
    logic [31:0] v;
    v = '0;
    case (addr)
      2'd0: begin
        v[0] = (rxQ.size() != 0);
        v[1] = (txQ.size() == DEPTH);
        v[2] = mRxOvr;
        v[3] = mTxUnr;
        v[4] = mSel;
        v[8] = mRxIe;
        v[9] = mTxIe;
      end
      2'd1: if (rxQ.size() != 0) v = {1'b1, 23'd0, rxQ.pop_front()};
      2'd2: begin
        v[7:0]  = 8'(rxQ.size());
        v[15:8] = 8'(txQ.size());
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void modelWrite(input logic [1:0] addr, input logic [31:0] data);
    if (addr == 2'd0) begin
      if (data[2]) mRxOvr = 1'b0;
      if (data[3]) mTxUnr = 1'b0;
`ifdef SPI_TARGET_IRQ_EN
      mRxIe = data[8];
      mTxIe = data[9];
`endif
    end else if (addr == 2'd1) begin
      if (txQ.size() < DEPTH) txQ.push_back(data[7:0]);
    end
  endfunction

  function automatic logic expIrq();
`ifdef SPI_TARGET_IRQ_EN
    return (mRxIe && rxQ.size() != 0) || (mTxIe && txQ.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Bus outputs are meaningful every cycle: read data on ack, zero otherwise.
  always @(negedge clk) begin
    if (wbIf.wb_ack === 1'b1) begin
      if (expValid) checkOutput("wbRdata", wbIf.wb_rdata, expRdata);
    end else begin
      checkOutput("rdataIdle", wbIf.wb_rdata, 32'd0);
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wbAccess(input logic [1:0] addr, input logic we, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    if (we) begin
      modelWrite(addr, wdata);
      expValid = 1'b0;
    end else begin
      expRdata = modelRead(addr);
      expValid = 1'b1;
    end
    wbIf.wb_addr  = addr;
    wbIf.wb_we    = we;
    wbIf.wb_wdata = wdata;
    wbIf.wb_cyc   = 1'b1;
    do begin
      @(negedge clk);
      waitCycles++;
    end while (wbIf.wb_ack !== 1'b1 && waitCycles < 4);
    rdata = wbIf.wb_rdata;
    if (wbIf.wb_ack !== 1'b1) checkOutput("wbAckTimeout", 32'd0, 32'd1);
    wbIf.wb_cyc = 1'b0;
    wbIf.wb_we  = 1'b0;
  endtask

  task automatic wbWrite(input logic [1:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    wbAccess(addr, 1'b1, data, dummy);
  endtask

  task automatic wbRead(input logic [1:0] addr, output logic [31:0] data);
    wbAccess(addr, 1'b0, 32'd0, data);
  endtask

  task automatic checkIrq();
    waitClk(3);
    checkOutput("irq", {31'd0, irq}, {31'd0, expIrq()});
  endtask

  task automatic csAssert();
    @(negedge clk);
    spiCs = 1'b0;
    waitClk(8);
    mSel    = 1'b1;
    mCurTx  = modelTxFetch();
    mBitCnt = 0;
    checkOutput("misoOeOn", {31'd0, misoOe}, 32'd1);
  endtask

  task automatic csDeassert();
    @(negedge clk);
    spiCs = 1'b1;
    waitClk(8);
    mSel    = 1'b0;
    mBitCnt = 0;
    checkOutput("misoOeOff", {31'd0, misoOe}, 32'd0);
  endtask

  // Clocks nBits of mosiByte out MSB first and collects what the master sampled.
  task automatic applyStimulus(input logic [7:0] mosiByte, input int nBits, output logic [7:0] misoByte);
    misoByte = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      spiMosi = mosiByte[7-i];
      waitClk(HALF);
      checkOutput("misoBit", {31'd0, miso}, {31'd0, mCurTx[7-mBitCnt]});
      misoByte = {misoByte[6:0], miso};
      spiClk = 1'b1;
      waitClk(HALF);
      mRxShift = {mRxShift[6:0], mosiByte[7-i]};
      mBitCnt++;
      if (mBitCnt == 8) begin
        mBitCnt = 0;
        if (rxQ.size() < DEPTH) rxQ.push_back(mRxShift);
        else mRxOvr = 1'b1;
      end
      spiClk = 1'b0;
      waitClk(HALF);
      if (mBitCnt == 0) mCurTx = modelTxFetch();
    end
  endtask

  task automatic drainRx();
    logic [31:0] d;
    while (rxQ.size() != 0) wbRead(2'd1, d);
    wbRead(2'd1, d);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  mb;
    logic [7:0]  sent[17];
    logic [7:0]  burstTx[3];
    int          nTx, nBytes, nBits;

    spiClk = 1'b0; spiCs = 1'b1; spiMosi = 1'b0;
    wbIf.wb_cyc = 1'b0; wbIf.wb_we = 1'b0; wbIf.wb_addr = 2'd0; wbIf.wb_wdata = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    waitClk(3);
    checkOutput("resetMiso",  {31'd0, miso},   32'd0);
    checkOutput("resetOe",    {31'd0, misoOe}, 32'd0);
    checkOutput("resetIrq",   {31'd0, irq},    32'd0);
    checkOutput("resetAck",   {31'd0, wbIf.wb_ack}, 32'd0);
    checkOutput("resetRdata", wbIf.wb_rdata,   32'd0);
    @(negedge clk);
    rst = 1'b0;
    waitClk(2);
    wbRead(2'd0, d); checkOutput("csrAfterReset", d, 32'd0);
    wbRead(2'd2, d); checkOutput("levelAfterReset", d, 32'd0);

    $display("[TB] basic exchange");
    wbWrite(2'd1, 32'hA5);
    csAssert();
    applyStimulus(8'h3C, 8, mb);
    csDeassert();
    checkOutput("basicMiso", {24'd0, mb}, 32'hA5);
    wbRead(2'd1, d); checkOutput("basicRx", d, 32'h8000003C);
    wbRead(2'd1, d); checkOutput("basicRxEmpty", d, 32'h0);
    wbWrite(2'd0, 32'hC);

    $display("[TB] tx underrun");
    csAssert();
    applyStimulus(8'($urandom), 8, mb);
    csDeassert();
    checkOutput("underrunMiso", {24'd0, mb}, 32'hFF);
    wbRead(2'd0, d); checkOutput("underrunSet", {31'd0, d[3]}, 32'd1);
    wbWrite(2'd0, 32'h8);
    wbRead(2'd0, d); checkOutput("underrunClear", {31'd0, d[3]}, 32'd0);
    drainRx();

    $display("[TB] rx overrun");
    csAssert();
    for (int k = 0; k < 17; k++) begin
      sent[k] = 8'($urandom);
      applyStimulus(sent[k], 8, mb);
    end
    csDeassert();
    wbRead(2'd2, d); checkOutput("overrunLevel", {24'd0, d[7:0]}, 32'd16);
    wbRead(2'd0, d); checkOutput("overrunFlag", {31'd0, d[2]}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      wbRead(2'd1, d);
      checkOutput("overrunOrder", d, {1'b1, 23'd0, sent[k]});
    end
    wbWrite(2'd0, 32'hC);

    $display("[TB] burst");
    burstTx[0] = 8'h11; burstTx[1] = 8'h22; burstTx[2] = 8'h33;
    for (int k = 0; k < 3; k++) wbWrite(2'd1, {24'd0, burstTx[k]});
    csAssert();
    wbRead(2'd0, d); checkOutput("selectedBit", {31'd0, d[4]}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'($urandom), 8, mb);
      checkOutput("burstMiso", {24'd0, mb}, {24'd0, burstTx[k]});
    end
    csDeassert();
    wbRead(2'd2, d); checkOutput("burstLevel", {24'd0, d[7:0]}, 32'd3);
    drainRx();
    wbWrite(2'd0, 32'hC);

    $display("[TB] partial byte");
    wbWrite(2'd1, 32'h44);
    wbWrite(2'd1, 32'h55);
    csAssert();
    applyStimulus(8'($urandom), 5, mb);
    csDeassert();
    csAssert();
    applyStimulus(8'h5A, 8, mb);
    csDeassert();
    checkOutput("partialMiso", {24'd0, mb}, 32'h55);
    wbRead(2'd2, d); checkOutput("partialLevel", {24'd0, d[7:0]}, 32'd1);
    wbRead(2'd1, d); checkOutput("partialRx", d, 32'h8000005A);
    wbWrite(2'd0, 32'hC);

    $display("[TB] random traffic");
    for (int it = 0; it < 20; it++) begin
      nTx = $urandom_range(0, 3);
      for (int k = 0; k < nTx; k++) wbWrite(2'd1, $urandom);
      nBytes = $urandom_range(1, 3);
      csAssert();
      for (int b = 0; b < nBytes; b++) begin
        nBits = (b == nBytes - 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
        applyStimulus(8'($urandom), nBits, mb);
      end
      csDeassert();
      wbRead(2'd0, d);
      wbRead(2'd2, d);
      wbWrite(2'd0, {22'd0, 2'($urandom), 4'd0, 2'($urandom), 2'd0});
      checkIrq();
      drainRx();
      checkIrq();
    end

    $display("[TB] interrupt");
    wbWrite(2'd0, 32'h10C);
    checkIrq();
    csAssert();
    applyStimulus(8'($urandom), 8, mb);
    csDeassert();
    checkIrq();
`ifdef SPI_TARGET_IRQ_EN
    checkOutput("irqRxPending", {31'd0, irq}, 32'd1);
`else
    checkOutput("irqTiedLow", {31'd0, irq}, 32'd0);
`endif
    wbRead(2'd1, d);
    checkIrq();
    checkOutput("irqDrained", {31'd0, irq}, 32'd0);

    $display("[TB] reset mid-byte");
    wbWrite(2'd1, 32'h77);
    wbWrite(2'd1, 32'h78);
    csAssert();
    applyStimulus(8'($urandom), 4, mb);
    spiClk = 1'b1;
    waitClk(2);
    rst = 1'b1;
    waitClk(1);
    checkOutput("midResetMiso", {31'd0, miso},   32'd0);
    checkOutput("midResetOe",   {31'd0, misoOe}, 32'd0);
    checkOutput("midResetIrq",  {31'd0, irq},    32'd0);
    checkOutput("midResetAck",  {31'd0, wbIf.wb_ack}, 32'd0);
    rxQ.delete(); txQ.delete();
    mRxOvr = 1'b0; mTxUnr = 1'b0; mRxIe = 1'b0; mTxIe = 1'b0; mSel = 1'b0; mBitCnt = 0;
    spiClk = 1'b0;
    spiCs  = 1'b1;
    waitClk(2);
    rst = 1'b0;
    waitClk(4);
    wbRead(2'd2, d); checkOutput("levelPostReset", d, 32'd0);
    wbRead(2'd0, d); checkOutput("csrPostReset", d, 32'd0);
    checkOutput("oePostReset", {31'd0, misoOe}, 32'd0);

    waitClk(2);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    #3ms;
    errCount++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (responder) in mode 0, MSB first, with a Wishbone CSR interface, RX/TX byte FIFOs and an interrupt. It sits on the peripheral bus alongside the platform SPI initiator and timer. It lets the SoC answer an external SPI master: a debug host, a bootloader feeder or a second FPGA. All pad signals are oversampled in the `clk` domain; there is no second clock.

## Interface
- `RX_DEPTH_LOG2`, 4: RX FIFO depth is 2^N bytes.
- `TX_DEPTH_LOG2`, 4: TX FIFO depth is 2^N bytes.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_pad_clk`  in  1  SCLK from the external master; asynchronous.
- `spi_pad_cs_n`  in  1  chip select, active low; asynchronous.
- `spi_pad_mosi`  in  1  data from the master; asynchronous.
- `spi_pad_miso`  out  1  data to the master.
- `spi_pad_miso_oe`  out  1  MISO output enable; high only while selected.
- `irqo_spi`  out  1  level interrupt.
- `wb_addr`  in  2  word address.
- `wb_rdata`  out  32  read data.
- `wb_wdata`  in  32  write data.
- `wb_we`  in  1  write enable.
- `wb_cyc`  in  1  cycle.
- `wb_ack`  out  1  acknowledge.

## Operation
- **Synchronisers:** `spi_pad_clk`, `spi_pad_cs_n` and `spi_pad_mosi` each pass through 2 flops. Reset values: 0, 1, 0. A third flop on SCLK gives `sclk_rise` and `sclk_fall` pulses. A third flop on CS gives `cs_fall` and `cs_rise` pulses.
- **Selected** means the synchronised CS is low. `spi_pad_miso_oe` is a register of "selected".
- **`cs_fall`:**
  - Clear `bit_cnt`.
  - Load the TX shifter from the TX FIFO head and pop it.
  - If the TX FIFO is empty, load 0xFF instead and set sticky `tx_underrun`.
- **`sclk_rise` while selected:** shift the synchronised MOSI into the RX shifter LSB and increment `bit_cnt` (3-bit, wraps). On the 8th rise (`bit_cnt` 7→0), push the RX byte into the RX FIFO. If the RX FIFO is full, drop the byte and set sticky `rx_overrun`.
- **`sclk_fall` while selected:**
  - If `bit_cnt`==0, load the next TX byte using the `cs_fall` rule (pop, or 0xFF plus underrun).
  - Otherwise shift the TX shifter left.
  - `spi_pad_miso` is the registered shifter bit 7.
- **`cs_rise`:** discard any partial byte (no push), clear `bit_cnt`, drop `spi_pad_miso_oe`.
- **SCLK edges while deselected** are ignored.
- **Wishbone:** `wb_ack` <= `wb_cyc` & ~`wb_ack`. `wb_rdata` is registered and forced to 0 when ~`wb_cyc` | `wb_ack`. Access strobe: `wb_cyc` & ~`wb_ack`.
- **addr 0, CSR:**
  - Read: [0] RX not empty, [1] TX full, [2] `rx_overrun`, [3] `tx_underrun`, [4] selected, [8] `rx_irq_en`, [9] `tx_irq_en`.
  - Write: [2] and [3] are write-1-to-clear; [8] and [9] load.
- **addr 1, DATA:**
  - Read returns {RX not empty, 23'd0, RX head}. The RX FIFO pops on the strobe cycle only if it is not empty.
  - Write pushes `wb_wdata[7:0]` into the TX FIFO. The write is silently dropped if the FIFO is full.
- **addr 2, LEVEL:** read returns RX level in [7:0] and TX level in [15:8], each zero-extended.
- **addr 3:** reads 0; writes are ignored.
- **FIFO arithmetic:** the level is DEPTH_LOG2+1 bits. Pointers wrap modulo depth.
  - A push and a pop in the same cycle leave the level unchanged.
  - A push to a full FIFO is accepted if a pop occurs in the same cycle.
  - A pop from an empty FIFO is a no-op.
- **Sticky flag conflict:** if a set and a W1C hit the same cycle, the set wins.
- **`irqo_spi`:** registered (`rx_irq_en` & RX not empty) | (`tx_irq_en` & TX empty).

## Timing
- **Reset values:** `spi_pad_miso`=0, `spi_pad_miso_oe`=0, `irqo_spi`=0, `wb_ack`=0, `wb_rdata`=0. FIFOs empty, flags and enables 0, `bit_cnt`=0.
- **Pad to internal event:** 3 `clk` cycles from a pad edge to its `sclk_*`/`cs_*` pulse. MISO changes 1 cycle after the pulse.
- **SCLK limit:** at most `clk`/8, with each SCLK phase ≥4 `clk` cycles. At that rate MISO is valid ≥1 `clk` before the master's rising edge.
- **CS setup:** CS low to first SCLK rise ≥4 `clk` cycles.
- **Bus latency:** 1 cycle; data and ack arrive together. An RX byte pushed at cycle N is readable from cycle N+1. A CSR write takes effect the cycle after the strobe.
- **Reset mid-transfer:** immediately returns to reset state. Partial bytes and all FIFO contents are lost.

## Configuration
- `SPI_TARGET_IRQ_EN` defined: `rx_irq_en`/`tx_irq_en` and `irqo_spi` behave as above.
- Not defined: CSR bits [9:8] read 0 and ignore writes; `irqo_spi` is tied 0; no interrupt logic is synthesised.

## Structure
- **Shared package:** CSR address constants (CSR=0, DATA=1, LEVEL=2), CSR bit indices, and the 0xFF underrun fill byte.
- **Sub-module `spi_target_fifo`:** parameterised by width and DEPTH_LOG2. Ports: push, pop, data in/out, empty, full, level. Instantiated twice.

## Test plan
- **Basic exchange:** write DATA=0xA5, select, master sends 0x3C at `clk`/8 → MISO carries 0xA5 MSB first; DATA read returns 0x8000003C, next read returns 0x00000000.
- **TX underrun:** TX empty at `cs_fall` → MISO carries 0xFF and CSR[3]=1; write CSR 0x8 → CSR[3]=0.
- **RX overrun:** send 17 bytes without reading → LEVEL[7:0]=16, CSR[2]=1, and reads return bytes 1..16 in order.
- **Burst in one select:** TX loaded with 0x11, 0x22, 0x33, three bytes clocked → MISO sequence is 0x11, 0x22, 0x33; RX holds all three master bytes.
- **Partial byte:** deselect after 5 bits, then a full byte 0x5A → only 0x5A is in RX and the TX byte order stays aligned.
- **Interrupt and reset:** `rx_irq_en`=1, one byte received → `irqo_spi`=1 until the RX FIFO is drained; assert `rst` mid-byte → all outputs at reset values and LEVEL=0.
